bullet_engine: RTL and testbench

- Per-player projectile generator and collision checker; one instance per player.
- Spawns bullets on fire presses and advances them once per frame tick.
- Detects overlap with the opposing player's hitbox and emits a one-cycle hit pulse.
- hit_o feeds the game FSM's bullet_collide_player input for the opponent. The FSM's reset/playing outputs drive clear_i/enable_i here.

---
 rtl/bullet_engine.sv | 188 ++++++++++++++++++
 tb/tb_bullet_engine.sv | 269 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/bullet_engine.sv
// bullet_engine: per-player projectile spawner, mover and hit detector.
// Optional feature macro BULLET_AUTOFIRE_EN: a held fire button retriggers each time the cooldown expires.
module bullet_engine #(
  parameter int N_BULLETS = 4,
  parameter int XW        = 10,
  parameter int YW        = 10,
  parameter int SCREEN_W  = 640,
  parameter int SPEED     = 4,
  parameter int TGT_W     = 16,
  parameter int TGT_H     = 16,
  parameter int COOLDOWN  = 8
) (
  input  logic                    clk_i,
  input  logic                    reset_ni,
  input  logic                    clear_i,
  input  logic                    enable_i,
  input  logic                    frame_tick_i,
  input  logic                    fire_i,
  input  logic                    dir_i,
  input  logic [XW-1:0]           shooter_x_i,
  input  logic [YW-1:0]           shooter_y_i,
  input  logic [XW-1:0]           target_x_i,
  input  logic [YW-1:0]           target_y_i,
  output logic [N_BULLETS*XW-1:0] bullet_x_o,
  output logic [N_BULLETS*YW-1:0] bullet_y_o,
  output logic [N_BULLETS-1:0]    bullet_active_o,
  output logic                    fire_ack_o,
  output logic                    hit_o
);

  localparam int            CW        = (COOLDOWN > 0) ? $clog2(COOLDOWN + 1) : 1;
  localparam logic [CW-1:0] COOL_LOAD = CW'(COOLDOWN);
  localparam logic [XW:0]   SPEED_X   = (XW+1)'(SPEED);
  localparam logic [XW:0]   SCREEN_X  = (XW+1)'(SCREEN_W);
  localparam logic [XW:0]   TGT_W_X   = (XW+1)'(TGT_W);
  localparam logic [YW:0]   TGT_H_Y   = (YW+1)'(TGT_H);

  typedef enum logic {
    S_FREE,
    S_FLYING
  } slot_state_e;

  slot_state_e   r_state [N_BULLETS];
  logic [XW-1:0] r_x     [N_BULLETS];
  logic [YW-1:0] r_y     [N_BULLETS];
  logic          r_dir   [N_BULLETS];
  logic [CW-1:0] r_cool;
  logic          r_fire_prev;
  logic          r_fire_ack;
  logic          r_hit;

  slot_state_e    w_state [N_BULLETS];
  logic [XW-1:0]  w_x     [N_BULLETS];
  logic [YW-1:0]  w_y     [N_BULLETS];
  logic           w_dir   [N_BULLETS];
  logic [XW:0]    w_sum   [N_BULLETS];
  logic [XW:0]    w_diff  [N_BULLETS];
  logic [N_BULLETS-1:0] w_alloc_oh;
  logic [N_BULLETS-1:0] w_hit_vec;
  logic           w_found;
  logic           w_fire_edge;
  logic           w_fire_try;
  logic           w_cool_ok;
  logic           w_do_fire;
  logic [CW-1:0]  w_cool;

  // Hit window and lowest-free-slot search; a slot freed this cycle is
  // still FLYING here, so it only becomes allocatable next cycle.
  always_comb begin
    // NOTE: every combinational output gets a default first so no path can infer a latch.
    w_alloc_oh = '0;
    w_hit_vec  = '0;
    w_found    = 1'b0;
    for (int k = 0; k < N_BULLETS; k++) begin
      if (r_state[k] == S_FREE && !w_found) begin
        w_alloc_oh[k] = 1'b1;
        w_found       = 1'b1;
      end
      w_hit_vec[k] = enable_i && (r_state[k] == S_FLYING)
                     && ({1'b0, r_x[k]} >= {1'b0, target_x_i})
                     && ({1'b0, r_x[k]} <  ({1'b0, target_x_i} + TGT_W_X))
                     && ({1'b0, r_y[k]} >= {1'b0, target_y_i})
                     && ({1'b0, r_y[k]} <  ({1'b0, target_y_i} + TGT_H_Y));
    end
  end

  always_comb begin
    w_fire_edge = fire_i & ~r_fire_prev;
`ifdef BULLET_AUTOFIRE_EN
    // Cooldown reaching zero on this tick counts as expired, giving a period of COOLDOWN ticks.
    w_cool_ok  = (r_cool == '0) || (frame_tick_i && (r_cool == CW'(1)));
    w_fire_try = w_fire_edge || (fire_i && frame_tick_i);
`else
    w_cool_ok  = (r_cool == '0);
    w_fire_try = w_fire_edge;
`endif
    w_do_fire = enable_i && w_fire_try && w_cool_ok && w_found;

    w_cool = r_cool;
    if (w_do_fire) begin
      w_cool = COOL_LOAD;
    end else if (frame_tick_i && (r_cool != '0)) begin
      w_cool = r_cool - CW'(1);
    end
  end

  // Per-slot next state: hit beats move; a fresh allocation is always a FREE slot.
  always_comb begin
    for (int k = 0; k < N_BULLETS; k++) begin
      w_state[k] = r_state[k];
      w_x[k]     = r_x[k];
      w_y[k]     = r_y[k];
      w_dir[k]   = r_dir[k];
      w_sum[k]   = {1'b0, r_x[k]} + SPEED_X;
      w_diff[k]  = {1'b0, r_x[k]} - SPEED_X;
      if (w_hit_vec[k]) begin
        w_state[k] = S_FREE;
      end else if (enable_i && frame_tick_i && (r_state[k] == S_FLYING)) begin
        if (!r_dir[k]) begin
          if (w_sum[k] >= SCREEN_X) w_state[k] = S_FREE;
          else                      w_x[k]     = w_sum[k][XW-1:0];
        end else begin
          if ({1'b0, r_x[k]} < SPEED_X) w_state[k] = S_FREE;
          else                          w_x[k]     = w_diff[k][XW-1:0];
        end
      end else if (w_do_fire && w_alloc_oh[k]) begin
        w_state[k] = S_FLYING;
        w_x[k]     = shooter_x_i;
        w_y[k]     = shooter_y_i;
        w_dir[k]   = dir_i;
      end
    end
  end

  // NOTE: the slot arrays are a handful of flops, not a RAM, so they are reset like any other state.
  always_ff @(posedge clk_i or negedge reset_ni) begin
    if (!reset_ni) begin
      for (int k = 0; k < N_BULLETS; k++) begin
        r_state[k] <= S_FREE;
        r_x[k]     <= '0;
        r_y[k]     <= '0;
        r_dir[k]   <= 1'b0;
      end
      r_cool      <= '0;
      r_fire_prev <= 1'b0;
      r_fire_ack  <= 1'b0;
      r_hit       <= 1'b0;
    end else if (clear_i) begin
      for (int k = 0; k < N_BULLETS; k++) begin
        r_state[k] <= S_FREE;
        r_x[k]     <= '0;
        r_y[k]     <= '0;
        r_dir[k]   <= 1'b0;
      end
      r_cool      <= '0;
      r_fire_prev <= 1'b0;
      r_fire_ack  <= 1'b0;
      r_hit       <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments keep every register sampling pre-edge values.
      for (int k = 0; k < N_BULLETS; k++) begin
        r_state[k] <= w_state[k];
        r_x[k]     <= w_x[k];
        r_y[k]     <= w_y[k];
        r_dir[k]   <= w_dir[k];
      end
      r_cool      <= w_cool;
      r_fire_prev <= fire_i;
      r_fire_ack  <= w_do_fire;
      r_hit       <= |w_hit_vec;
    end
  end

  always_comb begin
    bullet_x_o      = '0;
    bullet_y_o      = '0;
    bullet_active_o = '0;
    for (int k = 0; k < N_BULLETS; k++) begin
      bullet_x_o[k*XW +: XW] = r_x[k];
      bullet_y_o[k*YW +: YW] = r_y[k];
      bullet_active_o[k]     = (r_state[k] == S_FLYING);
    end
  end

  assign fire_ack_o = r_fire_ack;
  assign hit_o      = r_hit;

endmodule

// File: tb/tb_bullet_engine.sv
// tb_bullet_engine: scoreboard bench for bullet_engine (default parameters, autofire disabled).
module tb_bullet_engine;

  localparam int NB = 4;
  localparam int XW = 10;
  localparam int YW = 10;

  logic              clk_i = 1'b0;
  logic              reset_ni;
  logic              clear_i;
  logic              enable_i;
  logic              frame_tick_i;
  logic              fire_i;
  logic              dir_i;
  logic [XW-1:0]     shooter_x_i;
  logic [YW-1:0]     shooter_y_i;
  logic [XW-1:0]     target_x_i;
  logic [YW-1:0]     target_y_i;
  logic [NB*XW-1:0]  bullet_x_o;
  logic [NB*YW-1:0]  bullet_y_o;
  logic [NB-1:0]     bullet_active_o;
  logic              fire_ack_o;
  logic              hit_o;

  bullet_engine dut (
    .clk_i           (clk_i),
    .reset_ni        (reset_ni),
    .clear_i         (clear_i),
    .enable_i        (enable_i),
    .frame_tick_i    (frame_tick_i),
    .fire_i          (fire_i),
    .dir_i           (dir_i),
    .shooter_x_i     (shooter_x_i),
    .shooter_y_i     (shooter_y_i),
    .target_x_i      (target_x_i),
    .target_y_i      (target_y_i),
    .bullet_x_o      (bullet_x_o),
    .bullet_y_o      (bullet_y_o),
    .bullet_active_o (bullet_active_o),
    .fire_ack_o      (fire_ack_o),
    .hit_o           (hit_o)
  );

  always #5 clk_i = ~clk_i;

  typedef struct {
    int slot;
    int x;
    int y;
  } spawn_t;

  spawn_t ack_q [$];
  int     hit_q [$];
  spawn_t mon_e;
  int     hit_tag;
  int     n_checks = 0;
  int     n_errors = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
    end
  endtask

  task automatic step(input int n);
    repeat (n) begin
      @(posedge clk_i);
      #1;
    end
  endtask

  task automatic frames(input int n);
    repeat (n) begin
      frame_tick_i = 1'b1;
      step(1);
      frame_tick_i = 1'b0;
    end
  endtask

  // One-cycle fire press; exp_slot < 0 means the press must be dropped.
  task automatic press(input int x, input int y, input logic d, input int exp_slot);
    spawn_t e;
    shooter_x_i = XW'(x);
    shooter_y_i = YW'(y);
    dir_i       = d;
    if (exp_slot >= 0) begin
      e.slot = exp_slot;
      e.x    = x;
      e.y    = y;
      ack_q.push_back(e);
    end
    fire_i = 1'b1;
    step(1);
    fire_i = 1'b0;
    step(1);
  endtask

  function automatic int slot_x(input int k);
    return int'(bullet_x_o[k*XW +: XW]);
  endfunction

  // Scoreboard monitor: every spawn / hit pulse must match a queued expectation.
  always @(negedge clk_i) begin
    if (reset_ni) begin
      if (fire_ack_o) begin
        if (ack_q.size() == 0) begin
          check("ack_unexpected", 1, 0);
        end else begin
          mon_e = ack_q.pop_front();
          check("spawn_active", bullet_active_o[mon_e.slot], 1);
          check("spawn_x", bullet_x_o[mon_e.slot*XW +: XW], mon_e.x);
          check("spawn_y", bullet_y_o[mon_e.slot*YW +: YW], mon_e.y);
        end
      end
      if (hit_o) begin
        if (hit_q.size() == 0) check("hit_unexpected", 1, 0);
        else hit_tag = hit_q.pop_front();
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1);
  end

  initial begin
    reset_ni     = 1'b0;
    clear_i      = 1'b0;
    enable_i     = 1'b0;
    frame_tick_i = 1'b0;
    fire_i       = 1'b0;
    dir_i        = 1'b0;
    shooter_x_i  = '0;
    shooter_y_i  = '0;
    target_x_i   = '0;
    target_y_i   = YW'(500);
    step(3);
    check("rst_active", bullet_active_o, 0);
    check("rst_x", bullet_x_o, 0);
    check("rst_y", bullet_y_o, 0);
    check("rst_ack", fire_ack_o, 0);
    check("rst_hit", hit_o, 0);
    reset_ni = 1'b1;
    enable_i = 1'b1;
    step(2);

    // First shot and movement: 100 + 3*4 = 112
    press(100, 200, 1'b0, 0);
    check("ack_one_cycle", fire_ack_o, 0);
    frames(3);
    check("move_x112", slot_x(0), 112);

    // Cooldown still 5 ticks: dropped
    press(150, 200, 1'b0, -1);
    check("cool_drop_mask", bullet_active_o, 4'b0001);

    // Bullet flies into target at (120,195)
    target_x_i = XW'(120);
    target_y_i = YW'(195);
    frames(1);
    check("pre_hit_x116", slot_x(0), 116);
    hit_q.push_back(1);
    frames(1);
    check("at_target_x120", slot_x(0), 120);
    check("at_target_active", bullet_active_o, 4'b0001);
    step(1);
    check("hit_pulse", hit_o, 1);
    check("hit_freed", bullet_active_o, 0);
    step(1);
    check("hit_one_cycle", hit_o, 0);
    check("hit_q_empty", hit_q.size(), 0);
    target_x_i = '0;
    target_y_i = YW'(500);

    // Right edge: 636 + 4 = 640 leaves the screen (8 ticks after the first shot)
    frames(3);
    press(636, 200, 1'b0, 0);
    frames(1);
    check("edge_right_free", bullet_active_o, 0);
    check("edge_right_nohit", hit_o, 0);
    frames(7);
    // Left edge: 3 < 4 leaves the screen
    press(3, 200, 1'b1, 0);
    frames(1);
    check("edge_left_free", bullet_active_o, 0);
    frames(7);

    // Two bullets inside the target in the same cycle
    press(200, 300, 1'b0, 0);
    frames(8);
    check("pair_a_x232", slot_x(0), 232);
    press(236, 300, 1'b0, 1);
    check("pair_mask", bullet_active_o, 4'b0011);
    target_x_i = XW'(230);
    target_y_i = YW'(295);
    hit_q.push_back(2);
    step(1);
    check("pair_hit", hit_o, 1);
    check("pair_freed", bullet_active_o, 0);
    step(1);
    check("pair_single_pulse", hit_o, 0);
    target_x_i = '0;
    target_y_i = YW'(500);
    frames(8);

    // Fill all slots, fifth press dropped
    for (int s = 0; s < NB; s++) begin
      press(0, 100, 1'b0, s);
      frames(8);
    end
    press(0, 100, 1'b0, -1);
    check("full_mask", bullet_active_o, 4'b1111);
    check("full_slot0_x", slot_x(0), 128);
    check("full_slot3_x", slot_x(3), 32);

    // Synchronous clear mid-flight, including cooldown
    clear_i = 1'b1;
    step(1);
    clear_i = 1'b0;
    check("clear_mask", bullet_active_o, 0);
    check("clear_x", bullet_x_o, 0);
    press(50, 60, 1'b0, 0);
    clear_i = 1'b1;
    step(1);
    clear_i = 1'b0;
    check("clear2_mask", bullet_active_o, 0);
    press(70, 80, 1'b1, 0);
    check("post_clear_mask", bullet_active_o, 4'b0001);

    // Asynchronous reset mid-cycle
    #2;
    reset_ni = 1'b0;
    #1;
    check("async_mask", bullet_active_o, 0);
    check("async_x", bullet_x_o, 0);
    check("async_y", bullet_y_o, 0);
    step(1);
    reset_ni = 1'b1;
    step(1);

    // Fire held across enable rising must not spawn
    enable_i = 1'b0;
    fire_i   = 1'b1;
    step(2);
    enable_i = 1'b1;
    step(3);
    check("held_fire_mask", bullet_active_o, 0);
    fire_i = 1'b0;
    step(1);
    press(10, 20, 1'b0, 0);
    enable_i = 1'b0;
    frames(1);
    check("disabled_hold_x", slot_x(0), 10);
    enable_i = 1'b1;
    frames(1);
    check("enabled_move_x", slot_x(0), 14);

    step(2);
    check("ack_q_empty", ack_q.size(), 0);
    check("hit_q_final", hit_q.size(), 0);
    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
